// File: rtl/dpram_fifo_pkg.sv
// Shared constants and pointer helpers for the dual-port-RAM FIFO controller.
// Optional almost-full/empty flags are enabled with DPRAM_FIFO_ALMOST_EN.
package dpram_fifo_pkg;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [31:0]   pword_t;

    function automatic pword_t ptr_mask(input int unsigned a);
        return (pword_t'(1) << (a + 1)) - pword_t'(1);
    endfunction

    // Full when only the wrap bit differs.
    function automatic logic ptr_full(input pword_t w, input pword_t r,
                                      input int unsigned a);
        return ((w ^ r) & ptr_mask(a)) == (pword_t'(1) << a);
    endfunction

    function automatic logic ptr_empty(input pword_t w, input pword_t r,
                                       input int unsigned a);
        return ((w ^ r) & ptr_mask(a)) == '0;
    endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer handshake and status bundle of the FIFO controller.
// slave = controller side, master = user side.
interface dpram_fifo_ctrl_if
    import dpram_fifo_pkg::*;
#(
    parameter int aw = AW,
    parameter int dw = DW
);

    logic          clr;
    logic          wr_req;
    logic [dw-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic          rd_ack;
    logic          rd_valid;
    logic [dw-1:0] rd_data;
    logic          full;
    logic          empty;
    logic [aw:0]   count;
    logic          afull;
    logic          aempty;

    modport slave (
        input  clr, wr_req, wr_data, rd_req,
        output wr_ack, rd_ack, rd_valid, rd_data,
        output full, empty, count, afull, aempty
    );

    modport master (
        output clr, wr_req, wr_data, rd_req,
        input  wr_ack, rd_ack, rd_valid, rd_data,
        input  full, empty, count, afull, aempty
    );

endinterface

// File: rtl/dpram_fifo_ptr.sv
// Wrap-bit FIFO pointer: aw address bits plus one wrap bit.
// Synchronous clear, increment on inc.
module dpram_fifo_ptr
    import dpram_fifo_pkg::*;
#(
    parameter int aw = AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [aw:0] ptr
);

    localparam logic [aw:0] ONE = {{aw{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ONE;
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Single-clock FIFO controller driving both ports of a generic_dpram.
// Define DPRAM_FIFO_ALMOST_EN for registered almost-full/empty thresholds.
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
#(
    parameter int aw    = AW,
    parameter int dw    = DW,
    parameter int AF_TH = 28,
    parameter int AE_TH = 4
) (
    input  logic             clk,
    input  logic             rst,
    dpram_fifo_ctrl_if.slave fif,
    output logic [aw-1:0]    ram_waddr,
    output logic             ram_wce,
    output logic             ram_we,
    output logic [dw-1:0]    ram_din,
    output logic [aw-1:0]    ram_raddr,
    output logic             ram_rce,
    output logic             ram_oe,
    input  logic [dw-1:0]    ram_dout
);

    logic [aw:0] wptr;
    logic [aw:0] rptr;
    logic [aw:0] count;
    logic        full;
    logic        empty;
    logic        wr_ack;
    logic        rd_ack;
    logic        rd_valid;

    if (AE_TH >= AF_TH || AF_TH > (1 << aw)) begin : g_th_bad
        $error("dpram_fifo_ctrl: inconsistent almost thresholds");
    end

    assign full  = ptr_full(pword_t'(wptr), pword_t'(rptr), aw);
    assign empty = ptr_empty(pword_t'(wptr), pword_t'(rptr), aw);
    assign count = wptr - rptr;

    // Full refuses writes even with a concurrent read: raddr == waddr.
    assign wr_ack = fif.wr_req & ~full & ~fif.clr;
    assign rd_ack = fif.rd_req & ~empty & ~fif.clr;

    dpram_fifo_ptr #(.aw(aw)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (fif.clr),
        .inc (wr_ack),
        .ptr (wptr)
    );

    dpram_fifo_ptr #(.aw(aw)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (fif.clr),
        .inc (rd_ack),
        .ptr (rptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ack;
        end
    end

    assign ram_waddr = wptr[aw-1:0];
    assign ram_raddr = rptr[aw-1:0];
    assign ram_wce   = wr_ack;
    assign ram_we    = wr_ack;
    assign ram_rce   = rd_ack;
    assign ram_oe    = 1'b1;
    assign ram_din   = fif.wr_data;

    assign fif.wr_ack   = wr_ack;
    assign fif.rd_ack   = rd_ack;
    assign fif.rd_valid = rd_valid;
    assign fif.rd_data  = ram_dout;
    assign fif.full     = full;
    assign fif.empty    = empty;
    assign fif.count    = count;

`ifdef DPRAM_FIFO_ALMOST_EN
    localparam logic [aw:0] ONE  = {{aw{1'b0}}, 1'b1};
    localparam logic [aw:0] AF_C = (aw+1)'(AF_TH);
    localparam logic [aw:0] AE_C = (aw+1)'(AE_TH);

    logic [aw:0] cnt_nxt;
    logic        afull_q;
    logic        aempty_q;

    // Flags follow the next-state count so they line up with full/empty.
    always_comb begin
        cnt_nxt = count;
        if (fif.clr) begin
            cnt_nxt = '0;
        end else begin
            if (wr_ack) cnt_nxt = cnt_nxt + ONE;
            if (rd_ack) cnt_nxt = cnt_nxt - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            afull_q  <= (cnt_nxt >= AF_C);
            aempty_q <= (cnt_nxt <= AE_C);
        end
    end

    assign fif.afull  = afull_q;
    assign fif.aempty = aempty_q;
`else
    assign fif.afull  = full;
    assign fif.aempty = empty;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural dual-port RAM.
// Build with DPRAM_FIFO_ALMOST_EN to exercise the threshold flags.
module tb_dpram_fifo_ctrl;

    localparam int AW = 5;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic [AW-1:0] ram_waddr;
    logic          ram_wce;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_raddr;
    logic          ram_rce;
    logic          ram_oe;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] mem [1<<AW];

    dpram_fifo_ctrl_if #(.aw(AW), .dw(DW)) fif ();

    dpram_fifo_ctrl #(.aw(AW), .dw(DW), .AF_TH(28), .AE_TH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .fif       (fif),
        .ram_waddr (ram_waddr),
        .ram_wce   (ram_wce),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_raddr (ram_raddr),
        .ram_rce   (ram_rce),
        .ram_oe    (ram_oe),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: same-address read/write collision returns X.
    always @(posedge clk) begin
        if (ram_we && ram_wce) mem[ram_waddr] <= ram_din;
        if (ram_rce && ram_oe) begin
            if (ram_we && ram_wce && ram_waddr == ram_raddr)
                ram_dout <= 'x;
            else
                ram_dout <= mem[ram_raddr];
        end
    end

    int            checks;
    int            failures;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_d;
    logic          last_wack;
    logic          last_rack;
    logic          last_we;
    logic          last_rce;

    // Called at a negedge; returns at the following negedge.
    task automatic tick(input logic w, input logic r, input logic [DW-1:0] d);
        fif.wr_req  = w;
        fif.rd_req  = r;
        fif.wr_data = d;
        #1;
        last_wack = fif.wr_ack;
        last_rack = fif.rd_ack;
        last_we   = ram_we;
        last_rce  = ram_rce;
        if (last_wack === 1'b1) sb.push_back(d);
        @(posedge clk);
        @(negedge clk);
        fif.wr_req = 1'b0;
        fif.rd_req = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'(i));
        tick(1'b0, 1'b1, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (fif.empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_empty got=%b exp=1", fif.empty);
        end
        checks++;
        if (fif.full !== 1'b0) begin
            failures++;
            $display("FAIL reset_full got=%b exp=0", fif.full);
        end
        checks++;
        if (fif.count !== '0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", fif.count);
        end
        checks++;
        if (fif.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_valid got=%b exp=0", fif.rd_valid);
        end
        checks++;
        if (fif.afull !== 1'b0 || fif.aempty !== 1'b1) begin
            failures++;
            $display("FAIL reset_almost got=%b%b exp=01", fif.afull, fif.aempty);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_fill;
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, 1'b0, 16'(i));
            checks++;
            if (last_wack !== 1'b1 || fif.count !== 6'(i + 1)) begin
                failures++;
                $display("FAIL fill_%0d ack=%b count=%0d exp_count=%0d",
                         i, last_wack, fif.count, i + 1);
            end
            checks++;
            if (fif.full !== (i == 31)) begin
                failures++;
                $display("FAIL fill_full_%0d got=%b exp=%b", i, fif.full, i == 31);
            end
        end
        tick(1'b1, 1'b0, 16'h0099);
        checks++;
        if (last_wack !== 1'b0 || last_we !== 1'b0) begin
            failures++;
            $display("FAIL overfill ack=%b we=%b exp=0,0", last_wack, last_we);
        end
        checks++;
        if (fif.count !== 6'd32 || fif.full !== 1'b1) begin
            failures++;
            $display("FAIL overfill_count got=%0d full=%b exp=32,1", fif.count, fif.full);
        end
    endtask

    task automatic test_drain;
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 1'b1, 16'h0);
            checks++;
            if (last_rack !== 1'b1 || fif.rd_valid !== 1'b1) begin
                failures++;
                $display("FAIL drain_ack_%0d ack=%b valid=%b exp=1,1",
                         i, last_rack, fif.rd_valid);
            end
            exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
            checks++;
            if (fif.rd_data !== 16'(i) || exp_d !== 16'(i)) begin
                failures++;
                $display("FAIL drain_data_%0d got=%h exp=%h", i, fif.rd_data, 16'(i));
            end
        end
        checks++;
        if (fif.empty !== 1'b1 || fif.count !== '0) begin
            failures++;
            $display("FAIL drain_empty got=%b count=%0d exp=1,0", fif.empty, fif.count);
        end
        tick(1'b0, 1'b1, 16'h0);
        checks++;
        if (last_rack !== 1'b0 || last_rce !== 1'b0 || fif.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL underflow ack=%b rce=%b valid=%b exp=0,0,0",
                     last_rack, last_rce, fif.rd_valid);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0100 + 16'(i));
        for (int i = 0; i < 100; i++) begin
            tick(1'b1, 1'b1, 16'h0200 + 16'(i));
            checks++;
            if (last_wack !== 1'b1 || last_rack !== 1'b1 || fif.count !== 6'd3) begin
                failures++;
                $display("FAIL wrap_ack_%0d w=%b r=%b count=%0d exp=1,1,3",
                         i, last_wack, last_rack, fif.count);
            end
            exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
            checks++;
            if (fif.rd_valid !== 1'b1 || $isunknown(fif.rd_data) || fif.rd_data !== exp_d) begin
                failures++;
                $display("FAIL wrap_data_%0d valid=%b got=%h exp=%h",
                         i, fif.rd_valid, fif.rd_data, exp_d);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 16'h0);
            exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
            checks++;
            if (fif.rd_valid !== 1'b1 || fif.rd_data !== exp_d) begin
                failures++;
                $display("FAIL wrap_tail_%0d got=%h exp=%h", i, fif.rd_data, exp_d);
            end
        end
    endtask

    task automatic test_simultaneous;
        int guard;
        for (int i = 0; i < 32; i++) tick(1'b1, 1'b0, 16'h0300 + 16'(i));
        checks++;
        if (fif.full !== 1'b1) begin
            failures++;
            $display("FAIL sim_full got=%b exp=1", fif.full);
        end
        tick(1'b1, 1'b1, 16'h03AA);
        checks++;
        if (last_rack !== 1'b1 || last_wack !== 1'b0 || fif.count !== 6'd31) begin
            failures++;
            $display("FAIL sim_full_rw r=%b w=%b count=%0d exp=1,0,31",
                     last_rack, last_wack, fif.count);
        end
        exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        checks++;
        if (fif.rd_valid !== 1'b1 || fif.rd_data !== exp_d) begin
            failures++;
            $display("FAIL sim_data0 got=%h exp=%h", fif.rd_data, exp_d);
        end
        tick(1'b1, 1'b1, 16'h03BB);
        checks++;
        if (last_rack !== 1'b1 || last_wack !== 1'b1 || fif.count !== 6'd31) begin
            failures++;
            $display("FAIL sim_both r=%b w=%b count=%0d exp=1,1,31",
                     last_rack, last_wack, fif.count);
        end
        exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        checks++;
        if (fif.rd_valid !== 1'b1 || fif.rd_data !== exp_d) begin
            failures++;
            $display("FAIL sim_data1 got=%h exp=%h", fif.rd_data, exp_d);
        end
        guard = 0;
        while (fif.empty !== 1'b1 && guard < 40) begin
            tick(1'b0, 1'b1, 16'h0);
            exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
            checks++;
            if (fif.rd_valid !== 1'b1 || fif.rd_data !== exp_d) begin
                failures++;
                $display("FAIL sim_drain_%0d got=%h exp=%h", guard, fif.rd_data, exp_d);
            end
            guard++;
        end
        checks++;
        if (guard != 31 || sb.size() != 0) begin
            failures++;
            $display("FAIL sim_drain_len got=%0d left=%0d exp=31,0", guard, sb.size());
        end
    endtask

    task automatic test_clr;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 16'h0400 + 16'(i));
        checks++;
        if (fif.count !== 6'd10) begin
            failures++;
            $display("FAIL clr_pre_count got=%0d exp=10", fif.count);
        end
        fif.clr = 1'b1;
        tick(1'b1, 1'b1, 16'h04FF);
        fif.clr = 1'b0;
        checks++;
        if (last_rce !== 1'b0 || last_we !== 1'b0 || last_rack !== 1'b0 || last_wack !== 1'b0) begin
            failures++;
            $display("FAIL clr_access rce=%b we=%b r=%b w=%b exp=0,0,0,0",
                     last_rce, last_we, last_rack, last_wack);
        end
        checks++;
        if (fif.count !== '0 || fif.empty !== 1'b1 || fif.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr_state count=%0d empty=%b valid=%b exp=0,1,0",
                     fif.count, fif.empty, fif.rd_valid);
        end
        sb.delete();
        tick(1'b1, 1'b0, 16'h0555);
        tick(1'b0, 1'b1, 16'h0);
        exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        checks++;
        if (fif.rd_valid !== 1'b1 || fif.rd_data !== 16'h0555 || exp_d !== 16'h0555) begin
            failures++;
            $display("FAIL clr_reuse valid=%b got=%h exp=0555", fif.rd_valid, fif.rd_data);
        end
    endtask

    task automatic test_almost;
        int  n;
        logic exp_af;
        logic exp_ae;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (i < 32) begin
                tick(1'b1, 1'b0, 16'h0600 + 16'(i));
                n++;
            end else begin
                tick(1'b0, 1'b1, 16'h0);
                n--;
                exp_d = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
                checks++;
                if (fif.rd_valid !== 1'b1 || fif.rd_data !== exp_d) begin
                    failures++;
                    $display("FAIL almost_data_%0d got=%h exp=%h", i, fif.rd_data, exp_d);
                end
            end
`ifdef DPRAM_FIFO_ALMOST_EN
            exp_af = (n >= 28);
            exp_ae = (n <= 4);
`else
            exp_af = (n == 32);
            exp_ae = (n == 0);
`endif
            checks++;
            if (fif.count !== 6'(n) || fif.afull !== exp_af || fif.aempty !== exp_ae) begin
                failures++;
                $display("FAIL almost_%0d count=%0d af=%b ae=%b exp=%0d,%b,%b",
                         i, fif.count, fif.afull, fif.aempty, n, exp_af, exp_ae);
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        fif.clr     = 1'b0;
        fif.wr_req  = 1'b0;
        fif.rd_req  = 1'b0;
        fif.wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_clr();
        test_almost();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
